// File: rtl/axi_bus_arbiter.sv
// axi_bus_arbiter: two-port AXI4 arbiter onto a single AXI4 master.
//   clk, rst      : rising-edge clock; asynchronous active-low reset
//   s0_*          : port 0 (instruction bus), full AXI4 slave-side bundle
//   s1_*          : port 1 (data bus), full AXI4 slave-side bundle
//   m_*           : shared AXI4 master bundle
// Reads (AR/R) and writes (AW/W/B) have their own FSM and their own round-robin
// pointer, so one port can read while the other writes. Beats pass through
// combinationally; only the grant decision is registered.
module axi_bus_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   // port 0
   input  logic [ADDR_W-1:0]     s0_araddr,
   input  logic [7:0]            s0_arlen,
   input  logic [2:0]            s0_arsize,
   input  logic [1:0]            s0_arburst,
   input  logic                  s0_arvalid,
   output logic                  s0_arready,
   output logic [DATA_W-1:0]     s0_rdata,
   output logic [1:0]            s0_rresp,
   output logic                  s0_rlast,
   output logic                  s0_rvalid,
   input  logic                  s0_rready,
   input  logic [ADDR_W-1:0]     s0_awaddr,
   input  logic [7:0]            s0_awlen,
   input  logic [2:0]            s0_awsize,
   input  logic [1:0]            s0_awburst,
   input  logic                  s0_awvalid,
   output logic                  s0_awready,
   input  logic [DATA_W-1:0]     s0_wdata,
   input  logic [DATA_W/8-1:0]   s0_wstrb,
   input  logic                  s0_wlast,
   input  logic                  s0_wvalid,
   output logic                  s0_wready,
   output logic [1:0]            s0_bresp,
   output logic                  s0_bvalid,
   input  logic                  s0_bready,
   // port 1
   input  logic [ADDR_W-1:0]     s1_araddr,
   input  logic [7:0]            s1_arlen,
   input  logic [2:0]            s1_arsize,
   input  logic [1:0]            s1_arburst,
   input  logic                  s1_arvalid,
   output logic                  s1_arready,
   output logic [DATA_W-1:0]     s1_rdata,
   output logic [1:0]            s1_rresp,
   output logic                  s1_rlast,
   output logic                  s1_rvalid,
   input  logic                  s1_rready,
   input  logic [ADDR_W-1:0]     s1_awaddr,
   input  logic [7:0]            s1_awlen,
   input  logic [2:0]            s1_awsize,
   input  logic [1:0]            s1_awburst,
   input  logic                  s1_awvalid,
   output logic                  s1_awready,
   input  logic [DATA_W-1:0]     s1_wdata,
   input  logic [DATA_W/8-1:0]   s1_wstrb,
   input  logic                  s1_wlast,
   input  logic                  s1_wvalid,
   output logic                  s1_wready,
   output logic [1:0]            s1_bresp,
   output logic                  s1_bvalid,
   input  logic                  s1_bready,
   // shared master
   output logic [ADDR_W-1:0]     m_araddr,
   output logic [7:0]            m_arlen,
   output logic [2:0]            m_arsize,
   output logic [1:0]            m_arburst,
   output logic                  m_arvalid,
   input  logic                  m_arready,
   input  logic [DATA_W-1:0]     m_rdata,
   input  logic [1:0]            m_rresp,
   input  logic                  m_rlast,
   input  logic                  m_rvalid,
   output logic                  m_rready,
   output logic [ADDR_W-1:0]     m_awaddr,
   output logic [7:0]            m_awlen,
   output logic [2:0]            m_awsize,
   output logic [1:0]            m_awburst,
   output logic                  m_awvalid,
   input  logic                  m_awready,
   output logic [DATA_W-1:0]     m_wdata,
   output logic [DATA_W/8-1:0]   m_wstrb,
   output logic                  m_wlast,
   output logic                  m_wvalid,
   input  logic                  m_wready,
   input  logic [1:0]            m_bresp,
   input  logic                  m_bvalid,
   output logic                  m_bready
);

   typedef enum logic [1:0] {RIdle, RAddr, RData} rd_state_e;
   typedef enum logic [1:0] {WIdle, WAddr, WData, WResp} wr_state_e;

   rd_state_e rd_state_q, rd_state_d;
   wr_state_e wr_state_q, wr_state_d;
   logic      rd_grant_q, rd_grant_d, rd_last_q, rd_last_d;
   logic      wr_grant_q, wr_grant_d, wr_last_q, wr_last_d;

   // Round-robin pick: on a tie the port not served last wins.
   function automatic logic pick(input logic v0, input logic v1, input logic last);
      return (v0 & v1) ? ~last : v1;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_state_q <= RIdle;
         rd_grant_q <= 1'b0;
         rd_last_q  <= 1'b1;
         wr_state_q <= WIdle;
         wr_grant_q <= 1'b0;
         wr_last_q  <= 1'b1;
      end else begin
         rd_state_q <= rd_state_d;
         rd_grant_q <= rd_grant_d;
         rd_last_q  <= rd_last_d;
         wr_state_q <= wr_state_d;
         wr_grant_q <= wr_grant_d;
         wr_last_q  <= wr_last_d;
      end
   end

   // Read FSM next state
   always_comb begin
      rd_state_d = rd_state_q;
      rd_grant_d = rd_grant_q;
      rd_last_d  = rd_last_q;
      case (rd_state_q)
         RIdle: if (s0_arvalid | s1_arvalid) begin
            rd_grant_d = pick(s0_arvalid, s1_arvalid, rd_last_q);
            rd_state_d = RAddr;
         end
         RAddr: if (m_arvalid & m_arready) rd_state_d = RData;
         RData: if (m_rvalid & m_rready & m_rlast) begin
            rd_state_d = RIdle;
            rd_last_d  = rd_grant_q;
         end
         default: rd_state_d = RIdle;
      endcase
   end

   // Read path routing; everything idles at zero outside the owning state.
   always_comb begin
      m_araddr   = '0;
      m_arlen    = '0;
      m_arsize   = '0;
      m_arburst  = '0;
      m_arvalid  = 1'b0;
      m_rready   = 1'b0;
      s0_arready = 1'b0;
      s1_arready = 1'b0;
      s0_rdata   = '0;
      s0_rresp   = '0;
      s0_rlast   = 1'b0;
      s0_rvalid  = 1'b0;
      s1_rdata   = '0;
      s1_rresp   = '0;
      s1_rlast   = 1'b0;
      s1_rvalid  = 1'b0;
      if (rd_state_q == RAddr) begin
         m_araddr  = rd_grant_q ? s1_araddr  : s0_araddr;
         m_arlen   = rd_grant_q ? s1_arlen   : s0_arlen;
         m_arsize  = rd_grant_q ? s1_arsize  : s0_arsize;
         m_arburst = rd_grant_q ? s1_arburst : s0_arburst;
         m_arvalid = rd_grant_q ? s1_arvalid : s0_arvalid;
         s0_arready = ~rd_grant_q & m_arready;
         s1_arready = rd_grant_q & m_arready;
      end
      if (rd_state_q == RData) begin
         if (rd_grant_q) begin
            s1_rdata  = m_rdata;
            s1_rresp  = m_rresp;
            s1_rlast  = m_rlast;
            s1_rvalid = m_rvalid;
            m_rready  = s1_rready;
         end else begin
            s0_rdata  = m_rdata;
            s0_rresp  = m_rresp;
            s0_rlast  = m_rlast;
            s0_rvalid = m_rvalid;
            m_rready  = s0_rready;
         end
      end
   end

   // Write FSM next state
   always_comb begin
      wr_state_d = wr_state_q;
      wr_grant_d = wr_grant_q;
      wr_last_d  = wr_last_q;
      case (wr_state_q)
         WIdle: if (s0_awvalid | s1_awvalid) begin
            wr_grant_d = pick(s0_awvalid, s1_awvalid, wr_last_q);
            wr_state_d = WAddr;
         end
         WAddr: if (m_awvalid & m_awready) wr_state_d = WData;
         WData: if (m_wvalid & m_wready & m_wlast) wr_state_d = WResp;
         WResp: if (m_bvalid & m_bready) begin
            wr_state_d = WIdle;
            wr_last_d  = wr_grant_q;
         end
         default: wr_state_d = WIdle;
      endcase
   end

   // Write path routing
   always_comb begin
      m_awaddr   = '0;
      m_awlen    = '0;
      m_awsize   = '0;
      m_awburst  = '0;
      m_awvalid  = 1'b0;
      m_wdata    = '0;
      m_wstrb    = '0;
      m_wlast    = 1'b0;
      m_wvalid   = 1'b0;
      m_bready   = 1'b0;
      s0_awready = 1'b0;
      s1_awready = 1'b0;
      s0_wready  = 1'b0;
      s1_wready  = 1'b0;
      s0_bresp   = '0;
      s0_bvalid  = 1'b0;
      s1_bresp   = '0;
      s1_bvalid  = 1'b0;
      case (wr_state_q)
         WAddr: begin
            m_awaddr   = wr_grant_q ? s1_awaddr  : s0_awaddr;
            m_awlen    = wr_grant_q ? s1_awlen   : s0_awlen;
            m_awsize   = wr_grant_q ? s1_awsize  : s0_awsize;
            m_awburst  = wr_grant_q ? s1_awburst : s0_awburst;
            m_awvalid  = wr_grant_q ? s1_awvalid : s0_awvalid;
            s0_awready = ~wr_grant_q & m_awready;
            s1_awready = wr_grant_q & m_awready;
         end
         WData: begin
            m_wdata   = wr_grant_q ? s1_wdata  : s0_wdata;
            m_wstrb   = wr_grant_q ? s1_wstrb  : s0_wstrb;
            m_wlast   = wr_grant_q ? s1_wlast  : s0_wlast;
            m_wvalid  = wr_grant_q ? s1_wvalid : s0_wvalid;
            s0_wready = ~wr_grant_q & m_wready;
            s1_wready = wr_grant_q & m_wready;
         end
         WResp: begin
            if (wr_grant_q) begin
               s1_bresp  = m_bresp;
               s1_bvalid = m_bvalid;
               m_bready  = s1_bready;
            end else begin
               s0_bresp  = m_bresp;
               s0_bvalid = m_bvalid;
               m_bready  = s0_bready;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_axi_bus_arbiter.sv
// Self-checking bench for axi_bus_arbiter. The bench plays both masters and the
// shared slave; the reference model is transaction level: a round-robin pointer
// per path, the expected beat stream per burst, and a log of observed grants.
module tb_axi_bus_arbiter;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = DW / 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [1:0][AW-1:0] s_araddr, s_awaddr;
   logic [1:0][7:0]    s_arlen, s_awlen;
   logic [1:0][2:0]    s_arsize, s_awsize;
   logic [1:0][1:0]    s_arburst, s_awburst, s_rresp, s_bresp;
   logic [1:0][DW-1:0] s_rdata, s_wdata;
   logic [1:0][SW-1:0] s_wstrb;
   logic [1:0] s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
   logic [1:0] s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;

   logic [AW-1:0] m_araddr, m_awaddr;
   logic [7:0]    m_arlen, m_awlen;
   logic [2:0]    m_arsize, m_awsize;
   logic [1:0]    m_arburst, m_awburst, m_rresp, m_bresp;
   logic [DW-1:0] m_rdata, m_wdata;
   logic [SW-1:0] m_wstrb;
   logic m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
   logic m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;

   axi_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .s0_araddr(s_araddr[0]), .s0_arlen(s_arlen[0]), .s0_arsize(s_arsize[0]),
      .s0_arburst(s_arburst[0]), .s0_arvalid(s_arvalid[0]), .s0_arready(s_arready[0]),
      .s0_rdata(s_rdata[0]), .s0_rresp(s_rresp[0]), .s0_rlast(s_rlast[0]),
      .s0_rvalid(s_rvalid[0]), .s0_rready(s_rready[0]),
      .s0_awaddr(s_awaddr[0]), .s0_awlen(s_awlen[0]), .s0_awsize(s_awsize[0]),
      .s0_awburst(s_awburst[0]), .s0_awvalid(s_awvalid[0]), .s0_awready(s_awready[0]),
      .s0_wdata(s_wdata[0]), .s0_wstrb(s_wstrb[0]), .s0_wlast(s_wlast[0]),
      .s0_wvalid(s_wvalid[0]), .s0_wready(s_wready[0]),
      .s0_bresp(s_bresp[0]), .s0_bvalid(s_bvalid[0]), .s0_bready(s_bready[0]),
      .s1_araddr(s_araddr[1]), .s1_arlen(s_arlen[1]), .s1_arsize(s_arsize[1]),
      .s1_arburst(s_arburst[1]), .s1_arvalid(s_arvalid[1]), .s1_arready(s_arready[1]),
      .s1_rdata(s_rdata[1]), .s1_rresp(s_rresp[1]), .s1_rlast(s_rlast[1]),
      .s1_rvalid(s_rvalid[1]), .s1_rready(s_rready[1]),
      .s1_awaddr(s_awaddr[1]), .s1_awlen(s_awlen[1]), .s1_awsize(s_awsize[1]),
      .s1_awburst(s_awburst[1]), .s1_awvalid(s_awvalid[1]), .s1_awready(s_awready[1]),
      .s1_wdata(s_wdata[1]), .s1_wstrb(s_wstrb[1]), .s1_wlast(s_wlast[1]),
      .s1_wvalid(s_wvalid[1]), .s1_wready(s_wready[1]),
      .s1_bresp(s_bresp[1]), .s1_bvalid(s_bvalid[1]), .s1_bready(s_bready[1]),
      .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
      .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
      .m_rready(m_rready),
      .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
      .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
      .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
   );

   int n_checks = 0;
   int n_fail = 0;
   int rd_last_m;   // port served last on the read path
   int wr_last_m;   // port served last on the write path
   int rd_log[$];   // observed read grant order

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Round-robin expectation: a lone requester wins, a tie goes to the other port.
   function automatic int rr_winner(input logic [1:0] pend, input int last);
      if (pend == 2'b11) return (last == 1) ? 0 : 1;
      return pend[1] ? 1 : 0;
   endfunction

   // Read bursts from the ports in mask. bp: 0 always ready, 1 alternating, 2 random.
   // late: port 1 raises arvalid only once port 0's data phase has begun.
   task automatic read_txn(input logic [1:0] mask, input logic [AW-1:0] a0,
                           input logic [AW-1:0] a1, input logic [7:0] l0, input logic [7:0] l1,
                           input int bp, input int err_beat, input bit late);
      logic [1:0] pend;
      logic [DW-1:0] base;
      logic [1:0] rsp;
      int win, obs, cyc, beat, n;
      bit lt, raised;
      lt = late && (mask == 2'b11);
      s_araddr[0] = a0;
      s_araddr[1] = (a1 == a0) ? ~a0 : a1;
      s_arlen[0]  = l0;
      s_arlen[1]  = l1;
      pend = lt ? 2'b01 : mask;
      raised = !lt;
      s_arvalid = pend;
      while (pend != 2'b00) begin
         win = rr_winner(pend, rd_last_m);
         cyc = 0;
         do begin @(negedge clk); cyc++; end while (!m_arvalid && cyc < 20);
         check_eq("ar_latency", 64'(cyc), 64'd1);
         obs = (m_araddr == s_araddr[1]) ? 1 : 0;
         rd_log.push_back(obs);
         check_eq("ar_grant", 64'(obs), 64'(win));
         check_eq("ar_len", 64'(m_arlen), 64'(s_arlen[win]));
         check_eq("ar_size_burst", 64'({m_arsize, m_arburst}), 64'({s_arsize[win], s_arburst[win]}));
         m_arready = 1'b1;
         #1;
         check_eq("arready_grant", 64'(s_arready[win]), 64'd1);
         check_eq("arready_other", 64'(s_arready[1-win]), 64'd0);
         @(negedge clk);
         s_arvalid[win] = 1'b0;
         m_arready = 1'b0;
         pend[win] = 1'b0;
         n = int'(s_arlen[win]) + 1;
         beat = 0;
         cyc = 0;
         base = DW'($urandom);
         while (beat < n && cyc < 200) begin
            if (!raised && cyc == 1) begin
               s_arvalid[1] = 1'b1;
               pend[1] = 1'b1;
               raised = 1'b1;
            end
            rsp = (beat == err_beat) ? 2'd2 : 2'd0;
            m_rvalid = 1'b1;
            m_rdata  = base + DW'(beat);
            m_rresp  = rsp;
            m_rlast  = (beat == n - 1);
            s_rready[win] = (bp == 0) ? 1'b1 : (bp == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            s_rready[1-win] = 1'($urandom_range(0, 1));
            #1;
            check_eq("rvalid_grant", 64'(s_rvalid[win]), 64'd1);
            check_eq("rdata_grant", 64'(s_rdata[win]), 64'(base + DW'(beat)));
            check_eq("rresp_grant", 64'({s_rresp[win], s_rlast[win]}), 64'({rsp, beat == n - 1}));
            check_eq("rvalid_other", 64'(s_rvalid[1-win]), 64'd0);
            check_eq("m_rready", 64'(m_rready), 64'(s_rready[win]));
            if (pend[1-win]) check_eq("ar_holdoff", 64'(s_arready[1-win]), 64'd0);
            if (s_rready[win]) beat++;
            @(negedge clk);
            cyc++;
         end
         m_rvalid = 1'b0;
         m_rlast  = 1'b0;
         m_rdata  = '0;
         m_rresp  = '0;
         s_rready = '0;
         check_eq("r_beats", 64'(beat), 64'(n));
         rd_last_m = win;
      end
      if (mask != 2'b00) check_eq("r_idle_arvalid", 64'(m_arvalid), 64'd0);
   endtask

   // Write bursts from the ports in mask. bp: 0 slave always ready, otherwise random.
   task automatic write_txn(input logic [1:0] mask, input logic [AW-1:0] a0,
                            input logic [AW-1:0] a1, input logic [7:0] l0, input logic [7:0] l1,
                            input logic [SW-1:0] strb, input int bp);
      logic [1:0] pend;
      logic [DW-1:0] base;
      logic [1:0] rsp;
      int win, obs, cyc, beat, n;
      bit done;
      s_awaddr[0] = a0;
      s_awaddr[1] = (a1 == a0) ? ~a0 : a1;
      s_awlen[0]  = l0;
      s_awlen[1]  = l1;
      pend = mask;
      s_awvalid = pend;
      while (pend != 2'b00) begin
         win = rr_winner(pend, wr_last_m);
         cyc = 0;
         do begin @(negedge clk); cyc++; end while (!m_awvalid && cyc < 20);
         check_eq("aw_latency", 64'(cyc), 64'd1);
         obs = (m_awaddr == s_awaddr[1]) ? 1 : 0;
         check_eq("aw_grant", 64'(obs), 64'(win));
         check_eq("aw_len", 64'(m_awlen), 64'(s_awlen[win]));
         check_eq("aw_size_burst", 64'({m_awsize, m_awburst}), 64'({s_awsize[win], s_awburst[win]}));
         check_eq("w_quiet_in_aw", 64'({m_wvalid, m_bready, s_wready}), 64'd0);
         m_awready = 1'b1;
         #1;
         check_eq("awready_grant", 64'(s_awready[win]), 64'd1);
         check_eq("awready_other", 64'(s_awready[1-win]), 64'd0);
         @(negedge clk);
         s_awvalid[win] = 1'b0;
         m_awready = 1'b0;
         pend[win] = 1'b0;
         n = int'(s_awlen[win]) + 1;
         beat = 0;
         cyc = 0;
         base = DW'($urandom);
         while (beat < n && cyc < 200) begin
            s_wvalid[win] = 1'b1;
            s_wdata[win]  = base + DW'(beat);
            s_wstrb[win]  = strb;
            s_wlast[win]  = (beat == n - 1);
            m_wready = (bp == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            check_eq("m_wvalid", 64'(m_wvalid), 64'd1);
            check_eq("m_wdata", 64'(m_wdata), 64'(base + DW'(beat)));
            check_eq("m_wstrb_last", 64'({m_wstrb, m_wlast}), 64'({strb, beat == n - 1}));
            check_eq("wready_grant", 64'(s_wready[win]), 64'(m_wready));
            check_eq("wready_other", 64'(s_wready[1-win]), 64'd0);
            if (pend[1-win]) check_eq("aw_holdoff", 64'(s_awready[1-win]), 64'd0);
            if (m_wready) beat++;
            @(negedge clk);
            cyc++;
         end
         s_wvalid = '0;
         s_wlast  = '0;
         m_wready = 1'b0;
         check_eq("w_beats", 64'(beat), 64'(n));
         rsp = 2'($urandom_range(0, 3));
         m_bvalid = 1'b1;
         m_bresp  = rsp;
         done = 1'b0;
         cyc = 0;
         while (!done && cyc < 50) begin
            s_bready[win] = (bp == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            s_bready[1-win] = 1'($urandom_range(0, 1));
            #1;
            check_eq("bvalid_grant", 64'(s_bvalid[win]), 64'd1);
            check_eq("bresp_grant", 64'(s_bresp[win]), 64'(rsp));
            check_eq("b_other", 64'({s_bvalid[1-win], s_bresp[1-win]}), 64'd0);
            check_eq("m_bready", 64'(m_bready), 64'(s_bready[win]));
            done = s_bready[win];
            @(negedge clk);
            cyc++;
         end
         m_bvalid = 1'b0;
         m_bresp  = '0;
         s_bready = '0;
         check_eq("b_done", 64'(done), 64'd1);
         wr_last_m = win;
      end
      if (mask != 2'b00) check_eq("w_idle_awvalid", 64'(m_awvalid), 64'd0);
   endtask

   initial begin
      int cyc;
      logic [1:0] rm, wm;
      s_araddr = '0; s_arlen = '0; s_arvalid = '0; s_rready = '0;
      s_awaddr = '0; s_awlen = '0; s_awvalid = '0;
      s_wdata = '0; s_wstrb = '0; s_wlast = '0; s_wvalid = '0; s_bready = '0;
      // distinct size/burst per port so a wrong mux select is visible
      s_arsize[0] = 3'd2; s_arsize[1] = 3'd3; s_arburst[0] = 2'd1; s_arburst[1] = 2'd2;
      s_awsize[0] = 3'd2; s_awsize[1] = 3'd3; s_awburst[0] = 2'd1; s_awburst[1] = 2'd2;
      m_arready = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
      m_awready = 1'b0; m_wready = 1'b0; m_bresp = '0; m_bvalid = 1'b0;
      rst = 1'b0;
      rd_last_m = 1;
      wr_last_m = 1;
      repeat (3) @(negedge clk);
      s_arvalid = 2'b11;   // requests during reset must not be granted
      #1;
      check_eq("rst_m_out", 64'({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready}), 64'd0);
      check_eq("rst_s_out", 64'({s_arready, s_awready, s_wready, s_rvalid, s_bvalid}), 64'd0);
      @(negedge clk);
      check_eq("rst_hold_arvalid", 64'(m_arvalid), 64'd0);
      s_arvalid = '0;
      rst = 1'b1;
      @(negedge clk);

      // simultaneous reads, len 0: s0 wins the first tie, then alternation
      read_txn(2'b11, 32'h0000_0100, 32'h0000_1100, 8'd0, 8'd0, 0, -1, 1'b0);
      read_txn(2'b11, 32'h0000_0140, 32'h0000_1140, 8'd0, 8'd0, 0, -1, 1'b0);
      check_eq("grant_cnt", 64'(rd_log.size()), 64'd4);
      check_eq("grant_order0", 64'(rd_log[0]), 64'd0);
      check_eq("grant_order1", 64'(rd_log[1]), 64'd1);
      check_eq("grant_order2", 64'(rd_log[2]), 64'd0);

      // single read from s0, 4 beats
      read_txn(2'b01, 32'h0000_0100, 32'h0000_0200, 8'd3, 8'd0, 0, -1, 1'b0);

      // s0 read concurrent with s1 write
      fork
         read_txn(2'b01, 32'h0000_0300, 32'h0000_0400, 8'd3, 8'd0, 2, -1, 1'b0);
         write_txn(2'b10, 32'h0000_1000, 32'h0000_2000, 8'd0, 8'd1, 4'hF, 0);
      join

      // hold-off: s1 request arrives during s0 data phase
      read_txn(2'b11, 32'h0000_0500, 32'h0000_0600, 8'd3, 8'd1, 0, -1, 1'b1);

      // alternating rready backpressure with SLVERR on beat 2
      read_txn(2'b01, 32'h0000_0700, 32'h0000_0800, 8'd3, 8'd0, 1, 2, 1'b0);

      // reset during W_DATA
      s_awaddr[1] = 32'h0000_3000;
      s_awlen[1]  = 8'd3;
      s_awvalid[1] = 1'b1;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!m_awvalid && cyc < 20);
      check_eq("pre_rst_awvalid", 64'(m_awvalid), 64'd1);
      m_awready = 1'b1;
      @(negedge clk);
      s_awvalid[1] = 1'b0;
      m_awready = 1'b0;
      s_wvalid[1] = 1'b1;
      s_wdata[1]  = 32'hDEAD_BEEF;
      s_wstrb[1]  = 4'hF;
      m_wready = 1'b1;
      #1;
      check_eq("pre_rst_wdata", 64'(m_wdata), 64'h0000_0000_DEAD_BEEF);
      #1;
      rst = 1'b0;
      #1;
      check_eq("mid_rst_m_out", 64'({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready}), 64'd0);
      check_eq("mid_rst_s_out", 64'({s_arready, s_awready, s_wready, s_rvalid, s_bvalid}), 64'd0);
      check_eq("mid_rst_wdata", 64'(m_wdata), 64'd0);
      s_wvalid = '0;
      s_wdata  = '0;
      m_wready = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      rd_last_m = 1;
      wr_last_m = 1;
      @(negedge clk);
      write_txn(2'b10, 32'h0000_4000, 32'h0000_5000, 8'd0, 8'd2, 4'h5, 0);

      // randomized concurrent traffic
      for (int it = 0; it < 25; it++) begin
         rm = 2'($urandom_range(0, 3));
         wm = 2'($urandom_range(0, 3));
         fork
            read_txn(rm, AW'($urandom), AW'($urandom), 8'($urandom_range(0, 3)),
                     8'($urandom_range(0, 3)), 2, int'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)));
            write_txn(wm, AW'($urandom), AW'($urandom), 8'($urandom_range(0, 3)),
                      8'($urandom_range(0, 3)), SW'($urandom), 1);
         join
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

endmodule
